// File: rtl/alu_scheduler_if.sv
// Request/response/ALU bundle for alu_scheduler. The slave modport is the scheduler side;
// master is the requesters plus the external ALU.
interface alu_scheduler_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic [1:0] req0_op;
    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic [1:0] req1_op;

    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_overflow;
    logic       alu_zero;

    logic       rsp0_valid;
    logic       rsp0_ready;
    logic [3:0] rsp0_result;
    logic       rsp0_overflow;
    logic       rsp0_zero;
    logic       rsp1_valid;
    logic       rsp1_ready;
    logic [3:0] rsp1_result;
    logic       rsp1_overflow;
    logic       rsp1_zero;

    logic       busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, input req0_ready,
        output req1_valid, req1_a, req1_b, req1_op, input req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_overflow, alu_zero,
        input  rsp0_valid, rsp0_result, rsp0_overflow, rsp0_zero, output rsp0_ready,
        input  rsp1_valid, rsp1_result, rsp1_overflow, rsp1_zero, output rsp1_ready,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_overflow, alu_zero,
        output rsp0_valid, rsp0_result, rsp0_overflow, rsp0_zero, input rsp0_ready,
        output rsp1_valid, rsp1_result, rsp1_overflow, rsp1_zero, input rsp1_ready,
        output busy
    );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin sharing of one external 4-bit combinational ALU between two requesters.
// Optional grant counters are enabled with the ALU_SCHED_STATS_EN macro.
module alu_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    alu_scheduler_if.slave   bus
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [7:0]       gnt_cnt0,
    output logic [7:0]       gnt_cnt1
`endif
);

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

    state_e          state_q, state_d;
    logic            owner_q;
    logic            last_grant_q;
    logic [3:0]      cnt_q;
    logic [3:0]      alu_a_q, alu_b_q;
    logic [1:0]      alu_op_q;
    logic [1:0][3:0] rsp_result_q;
    logic [1:0]      rsp_overflow_q;
    logic [1:0]      rsp_zero_q;
    logic            grant0, grant1, accept0, accept1, accept;

    // last_grant_q==1 means port 1 was served last, so port 0 wins a tie
    always_comb begin
        grant0  = bus.req0_valid & (~bus.req1_valid | last_grant_q);
        grant1  = bus.req1_valid & ~grant0;
        accept0 = (state_q == StIdle) & grant0;
        accept1 = (state_q == StIdle) & grant1;
        accept  = accept0 | accept1;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StSettle;
            StSettle: if (cnt_q == 4'd0) state_d = StResp;
            StResp:   if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req0_ready    = accept0;
        bus.req1_ready    = accept1;
        bus.busy          = (state_q != StIdle);
        bus.rsp0_valid    = (state_q == StResp) & ~owner_q;
        bus.rsp1_valid    = (state_q == StResp) & owner_q;
        bus.rsp0_result   = rsp_result_q[0];
        bus.rsp0_overflow = rsp_overflow_q[0];
        bus.rsp0_zero     = rsp_zero_q[0];
        bus.rsp1_result   = rsp_result_q[1];
        bus.rsp1_overflow = rsp_overflow_q[1];
        bus.rsp1_zero     = rsp_zero_q[1];
        bus.alu_a         = alu_a_q;
        bus.alu_b         = alu_b_q;
        bus.alu_op        = alu_op_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            cnt_q          <= 4'd0;
            alu_a_q        <= 4'd0;
            alu_b_q        <= 4'd0;
            alu_op_q       <= 2'd0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= '0;
            rsp_zero_q     <= '0;
        end else begin
            if (accept) begin
                alu_a_q      <= accept1 ? bus.req1_a  : bus.req0_a;
                alu_b_q      <= accept1 ? bus.req1_b  : bus.req0_b;
                alu_op_q     <= accept1 ? bus.req1_op : bus.req0_op;
                owner_q      <= accept1;
                last_grant_q <= accept1;
                cnt_q        <= CntInit;
            end
            // Operands have now been stable for SETTLE_CYCLES cycles at the capture edge
            if (state_q == StSettle) begin
                if (cnt_q == 4'd0) begin
                    rsp_result_q[owner_q]   <= bus.alu_result;
                    rsp_overflow_q[owner_q] <= bus.alu_overflow;
                    rsp_zero_q[owner_q]     <= bus.alu_zero;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
        end
    end

`ifdef ALU_SCHED_STATS_EN
    logic [7:0] gnt_cnt0_q, gnt_cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0_q <= 8'd0;
            gnt_cnt1_q <= 8'd0;
        end else begin
            if (accept0 && (gnt_cnt0_q != 8'hff)) gnt_cnt0_q <= gnt_cnt0_q + 8'd1;
            if (accept1 && (gnt_cnt1_q != 8'hff)) gnt_cnt1_q <= gnt_cnt1_q + 8'd1;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`else
`endif

endmodule
